// File: rtl/cordic_pkg.sv
// Shared types and constants for the round-robin Cordic arbiter.
// The CORDIC_TIMEOUT_EN macro (see cordic_arbiter) does not affect this package.
package cordic_pkg;

  localparam int W_DEFAULT = 13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } state_t;

  // Requester ID width: ceil(log2(n)), never below one bit.
  function automatic int calc_idw(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/cordic_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module cordic_rr_pick
  import cordic_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = calc_idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  grant,
  output logic            valid
);

  int             sum;
  logic [IDW-1:0] idx;

  // Scan from the farthest candidate back to ptr so the closest one wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IDW'(sum);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin scheduler sharing one Cordic core between NREQ requesters.
// Optional watchdog on the WAIT state is enabled by defining CORDIC_TIMEOUT_EN.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int NREQ    = 4,
  parameter int IDW     = calc_idw(NREQ),
  parameter int TIMEOUT = 32
) (
  input  logic                CLK1,
  input  logic                RST_n,
  input  logic [NREQ-1:0]     Req,
  input  logic [NREQ*W-1:0]   I_in,
  input  logic [NREQ*W-1:0]   Q_in,
  output logic [NREQ-1:0]     Ack,
  output logic [W-1:0]        I,
  output logic [W-1:0]        Q,
  output logic                Cordic_Enable,
  input  logic                Cordic_Ready,
  input  logic [W-1:0]        AM,
  input  logic [W-1:0]        PM,
  output logic                Res_Valid,
  output logic [IDW-1:0]      Res_Id,
  output logic [W-1:0]        Res_AM,
  output logic [W-1:0]        Res_PM,
  output logic                Res_Err,
  output logic                Busy
);

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   i_q, i_d, q_q, q_d;
  logic [W-1:0]   am_q, am_d, pm_q, pm_d;

  logic [IDW-1:0] pick_grant;
  logic           pick_valid;
  logic [W-1:0]   i_arr [NREQ];
  logic [W-1:0]   q_arr [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_slice
    assign i_arr[k] = I_in[k*W +: W];
    assign q_arr[k] = Q_in[k*W +: W];
  end

  cordic_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (Req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

`ifdef CORDIC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    i_d     = i_q;
    q_d     = q_q;
    am_d    = am_q;
    pm_d    = pm_q;
`ifdef CORDIC_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          i_d     = i_arr[pick_grant];
          q_d     = q_arr[pick_grant];
          id_d    = pick_grant;
          ptr_d   = (pick_grant == IDW'(NREQ - 1)) ? '0 : pick_grant + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef CORDIC_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        // A result from the core takes priority over an expiring watchdog.
        if (Cordic_Ready) begin
          am_d    = AM;
          pm_d    = PM;
`ifdef CORDIC_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = RETURN;
`ifdef CORDIC_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          am_d    = '0;
          pm_d    = '0;
          err_d   = 1'b1;
          state_d = RETURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RETURN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK1 or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      i_q     <= '0;
      q_q     <= '0;
      am_q    <= '0;
      pm_q    <= '0;
`ifdef CORDIC_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      i_q     <= i_d;
      q_q     <= q_d;
      am_q    <= am_d;
      pm_q    <= pm_d;
`ifdef CORDIC_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    Ack = '0;
    if (state_q == ISSUE) Ack[id_q] = 1'b1;
  end

  assign I             = i_q;
  assign Q             = q_q;
  assign Cordic_Enable = (state_q == ISSUE);
  assign Res_Valid     = (state_q == RETURN);
  assign Res_Id        = id_q;
  assign Res_AM        = am_q;
  assign Res_PM        = pm_q;
  assign Busy          = (state_q != IDLE);

`ifdef CORDIC_TIMEOUT_EN
  assign Res_Err = err_q;
`else
  assign Res_Err = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed self-checking bench for cordic_arbiter; the timeout section follows CORDIC_TIMEOUT_EN.
module tb_cordic_arbiter;

  localparam int W       = 13;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 32;

  logic              CLK1 = 1'b0;
  logic              RST_n = 1'b0;
  logic [NREQ-1:0]   Req = '0;
  logic [NREQ*W-1:0] I_in = '0;
  logic [NREQ*W-1:0] Q_in = '0;
  logic              Cordic_Ready = 1'b0;
  logic [W-1:0]      AM = '0;
  logic [W-1:0]      PM = '0;

  logic [NREQ-1:0]   Ack;
  logic [W-1:0]      I;
  logic [W-1:0]      Q;
  logic              Cordic_Enable;
  logic              Res_Valid;
  logic [IDW-1:0]    Res_Id;
  logic [W-1:0]      Res_AM;
  logic [W-1:0]      Res_PM;
  logic              Res_Err;
  logic              Busy;

  int assert_count = 0;
  int fail_count   = 0;

  cordic_arbiter #(
    .W       (W),
    .NREQ    (NREQ),
    .IDW     (IDW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK1          (CLK1),
    .RST_n         (RST_n),
    .Req           (Req),
    .I_in          (I_in),
    .Q_in          (Q_in),
    .Ack           (Ack),
    .I             (I),
    .Q             (Q),
    .Cordic_Enable (Cordic_Enable),
    .Cordic_Ready  (Cordic_Ready),
    .AM            (AM),
    .PM            (PM),
    .Res_Valid     (Res_Valid),
    .Res_Id        (Res_Id),
    .Res_AM        (Res_AM),
    .Res_PM        (Res_PM),
    .Res_Err       (Res_Err),
    .Busy          (Busy)
  );

  always #5 CLK1 = ~CLK1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected test end");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK1);
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] req, input logic [NREQ*W-1:0] iv,
                               input logic [NREQ*W-1:0] qv);
    Req  = req;
    I_in = iv;
    Q_in = qv;
  endtask

  function automatic logic [NREQ*W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ack"}, 32'(Ack), 0);
    checkOutput({tag, "_i"}, 32'(I), 0);
    checkOutput({tag, "_q"}, 32'(Q), 0);
    checkOutput({tag, "_enable"}, 32'(Cordic_Enable), 0);
    checkOutput({tag, "_valid"}, 32'(Res_Valid), 0);
    checkOutput({tag, "_id"}, 32'(Res_Id), 0);
    checkOutput({tag, "_am"}, 32'(Res_AM), 0);
    checkOutput({tag, "_pm"}, 32'(Res_PM), 0);
    checkOutput({tag, "_err"}, 32'(Res_Err), 0);
    checkOutput({tag, "_busy"}, 32'(Busy), 0);
  endtask

  // Bounded wait for the start pulse; returns the number of cycles waited.
  task automatic waitEnable(output int n);
    n = 0;
    while (Cordic_Enable !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("enable_seen", 32'(Cordic_Enable), 1);
  endtask

  // One full transaction: ISSUE checks, core answers delay cycles after Enable, result checks.
  task automatic doTxn(input int exp_id, input int exp_i, input int exp_q, input int delay,
                       input int am, input int pm, input bit drop_req, input bit spurious);
    int n;
    waitEnable(n);
    checkOutput("enable_latency", n, 1);
    if (Cordic_Enable === 1'b1) begin
      checkOutput("ack_grant", 32'(Ack), 32'd1 << exp_id);
      checkOutput("i_out", 32'(I), exp_i);
      checkOutput("q_out", 32'(Q), exp_q);
      checkOutput("busy_issue", 32'(Busy), 1);
      if (drop_req) Req = '0;
      if (spurious) begin
        Cordic_Ready = 1'b1;
        AM = 13'h1FFF;
        PM = 13'd5;
      end
      tick();
      Cordic_Ready = 1'b0;
      checkOutput("ack_one_cycle", 32'(Ack), 0);
      checkOutput("enable_one_cycle", 32'(Cordic_Enable), 0);
      checkOutput("no_valid_in_wait", 32'(Res_Valid), 0);
      repeat (delay - 1) tick();
      checkOutput("busy_wait", 32'(Busy), 1);
      checkOutput("i_stable", 32'(I), exp_i);
      Cordic_Ready = 1'b1;
      AM = W'(am);
      PM = W'(pm);
      tick();
      Cordic_Ready = 1'b0;
      AM = '0;
      PM = '0;
      checkOutput("res_valid", 32'(Res_Valid), 1);
      checkOutput("res_id", 32'(Res_Id), exp_id);
      checkOutput("res_am", 32'(Res_AM), am);
      checkOutput("res_pm", 32'(Res_PM), pm);
      checkOutput("res_err", 32'(Res_Err), 0);
      tick();
      checkOutput("valid_one_cycle", 32'(Res_Valid), 0);
      checkOutput("res_am_hold", 32'(Res_AM), am);
    end
  endtask

  task automatic resetDut();
    RST_n = 1'b0;
    tick();
    tick();
    RST_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    int busy_cnt;
    int valid_cnt;

    #2;
    checkAllZero("reset");
    tick();
    RST_n = 1'b1;
    tick();

    // Single request, core answers 16 cycles after Enable.
    applyStimulus(4'b0001, pack4(100, 0, 0, 0), pack4(0, 0, 0, 0));
    doTxn(0, 100, 0, 16, 100, 0, 1'b1, 1'b0);

    // Fairness with all requesters streaming from pointer 0.
    resetDut();
    applyStimulus(4'b1111, pack4(11, 21, 31, 41), pack4(12, 22, 32, 42));
    doTxn(0, 11, 12, 3, 500, 1, 1'b0, 1'b0);
    doTxn(1, 21, 22, 4, 501, 2, 1'b0, 1'b0);
    doTxn(2, 31, 32, 2, 502, 3, 1'b0, 1'b0);
    doTxn(3, 41, 42, 5, 503, 4, 1'b0, 1'b0);
    doTxn(0, 11, 12, 3, 504, 5, 1'b1, 1'b0);

    // Pointer skip: serve 1, then 0101 gives 2 then wraps to 0.
    applyStimulus(4'b0010, pack4(11, 21, 31, 41), pack4(12, 22, 32, 42));
    doTxn(1, 21, 22, 3, 600, 6, 1'b1, 1'b0);
    applyStimulus(4'b0101, pack4(11, 21, 31, 41), pack4(12, 22, 32, 42));
    doTxn(2, 31, 32, 3, 601, 7, 1'b0, 1'b0);
    doTxn(0, 11, 12, 3, 602, 8, 1'b1, 1'b0);

    // Spurious Ready in IDLE, then in ISSUE.
    Cordic_Ready = 1'b1;
    tick();
    Cordic_Ready = 1'b0;
    checkOutput("spur_idle_busy", 32'(Busy), 0);
    checkOutput("spur_idle_valid", 32'(Res_Valid), 0);
    tick();
    checkOutput("spur_idle_valid2", 32'(Res_Valid), 0);
    checkOutput("spur_idle_am_hold", 32'(Res_AM), 602);
    applyStimulus(4'b0001, pack4(77, 0, 0, 0), pack4(88, 0, 0, 0));
    doTxn(0, 77, 88, 6, 700, 9, 1'b1, 1'b1);

    // Reset in the middle of WAIT.
    applyStimulus(4'b0010, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    waitEnable(n);
    Req = '0;
    tick();
    tick();
    tick();
    checkOutput("pre_reset_busy", 32'(Busy), 1);
    RST_n = 1'b0;
    #1;
    checkAllZero("midreset");
    tick();
    tick();
    RST_n = 1'b1;
    tick();
    checkOutput("post_reset_valid", 32'(Res_Valid), 0);
    checkOutput("post_reset_busy", 32'(Busy), 0);
    applyStimulus(4'b1001, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    doTxn(0, 1, 5, 4, 800, 10, 1'b1, 1'b0);
    applyStimulus(4'b0100, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    doTxn(2, 3, 7, 4, 801, 11, 1'b1, 1'b0);

    // Core never answers.
    applyStimulus(4'b0001, pack4(9, 0, 0, 0), pack4(10, 0, 0, 0));
    waitEnable(n);
    Req = '0;
`ifdef CORDIC_TIMEOUT_EN
    repeat (32) tick();
    checkOutput("to_not_early", 32'(Res_Valid), 0);
    tick();
    checkOutput("to_valid", 32'(Res_Valid), 1);
    checkOutput("to_err", 32'(Res_Err), 1);
    checkOutput("to_am", 32'(Res_AM), 0);
    checkOutput("to_pm", 32'(Res_PM), 0);
    checkOutput("to_id", 32'(Res_Id), 0);
    tick();
    checkOutput("to_idle", 32'(Busy), 0);
`else
    busy_cnt = 0;
    valid_cnt = 0;
    repeat (100) begin
      tick();
      if (Busy === 1'b1) busy_cnt++;
      if (Res_Valid === 1'b1) valid_cnt++;
    end
    checkOutput("hang_busy", busy_cnt, 100);
    checkOutput("hang_no_valid", valid_cnt, 0);
    checkOutput("hang_err", 32'(Res_Err), 0);
    resetDut();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
Round-robin scheduler that shares one Cordic core between NREQ requesters.
- Each requester presents an I/Q pair.
- The arbiter grants one request, issues it to the Cordic core with a single-cycle Cordic_Enable, and waits for Cordic_Ready.
- It returns the captured AM/PM on a shared result bus tagged with the requester ID.
- Sits between the per-channel Control front-ends and the Cordic core, all in the CLK1 domain.

Parameters:
W, 13, data width of I/Q/AM/PM.
NREQ, 4, number of requesters (2..4).
IDW, 2, requester ID width (ceil log2 NREQ, minimum 1).
TIMEOUT, 32, watchdog limit in cycles (used only with CORDIC_TIMEOUT_EN).

Ports:
CLK1  in  1  single clock; all logic rising-edge.
RST_n  in  1  asynchronous reset, active-low.
Req  in  NREQ  level request per requester.
I_in  in  NREQ*W  packed I per requester; slice k = [k*W+W-1:k*W].
Q_in  in  NREQ*W  packed Q per requester.
Ack  out  NREQ  one-cycle pulse: request k accepted, I/Q latched.
I  out  W  I to Cordic core.
Q  out  W  Q to Cordic core.
Cordic_Enable  out  1  one-cycle start pulse to Cordic core.
Cordic_Ready  in  1  one-cycle result strobe from Cordic core.
AM  in  W  magnitude from Cordic core.
PM  in  W  phase from Cordic core.
Res_Valid  out  1  one-cycle result strobe.
Res_Id  out  IDW  requester owning the result.
Res_AM  out  W  registered magnitude.
Res_PM  out  W  registered phase.
Res_Err  out  1  result aborted by watchdog.
Busy  out  1  state != IDLE.

Behaviour:
- Reset (async, RST_n low):
  - State IDLE, RR pointer 0.
  - All outputs 0: Ack, I, Q, Cordic_Enable, Res_*, Busy.
- Reset mid-operation: transaction is discarded and no Res_Valid is produced. The Cordic core shares RST_n.
- States: IDLE -> ISSUE -> WAIT -> RETURN -> IDLE.
- IDLE: if any Req bit is set:
  - Grant g = first set bit scanning circularly from the pointer.
  - Register I_in/Q_in slice g into I/Q and g into Res_Id.
  - Set pointer to (g+1) mod NREQ and go to ISSUE.
  - No Req set: remain in IDLE.
- ISSUE (1 cycle):
  - Ack[g]=1 and Cordic_Enable=1, both exactly this cycle.
  - Go to WAIT.
- WAIT:
  - Cordic_Ready=1: capture AM/PM into Res_AM/Res_PM, Res_Err=0, go to RETURN.
  - Cordic_Ready in any state other than WAIT is ignored.
- RETURN (1 cycle): Res_Valid=1, go to IDLE.
- Res_AM/Res_PM/Res_Id/Res_Err hold their values until the next capture.
- I/Q are stable from ISSUE until leaving WAIT.
- Latency: Req seen in IDLE at cycle 0 -> Cordic_Enable at cycle 1. Cordic_Ready at cycle n -> Res_Valid at cycle n+1. Next grant is decided at cycle n+2.
- Req is level-sensitive:
  - A requester that keeps Req high is served again at its next round-robin turn (streaming).
  - Req dropped before grant means the request is withdrawn.
- Req is sampled only in IDLE, so simultaneous requests are resolved purely by the pointer.
- A pointer wrap from NREQ-1 goes to 0.

Optional Feature:
Macro CORDIC_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without Cordic_Ready: go to RETURN with Res_AM=0, Res_PM=0, Res_Err=1.
  - If Cordic_Ready and the timeout occur in the same cycle, Ready wins.
- Undefined: WAIT is unbounded, no counter is built, and Res_Err is constant 0.

Decomposition:
- Package cordic_pkg: W default, state encoding constants (IDLE, ISSUE, WAIT, RETURN), IDW computation helper.
- Sub-module cordic_rr_pick: combinational round-robin picker. Inputs Req and pointer; outputs grant index and any-valid.

Test Plan:
- Single request:
  - Stimulus: Req=4'b0001, I_in slice0=100, Q_in slice0=0. Core model returns Ready 16 cycles after Enable with AM=100, PM=0.
  - Required: Ack[0] and Cordic_Enable coincide with I=100; Res_Valid one cycle after Ready; Res_Id=0, Res_AM=100, Res_PM=0.
- Fairness: Req=4'b1111 held high -> grant order 0,1,2,3,0; each Ack exactly one cycle.
- Pointer skip: after requester 1 is served, Req=4'b0101 -> grant 2, then 0; pointer wraps correctly.
- Spurious Ready: Cordic_Ready pulsed in IDLE and in ISSUE -> no state change, no Res_Valid.
- Reset mid-operation:
  - Stimulus: RST_n low during WAIT.
  - Required: all outputs 0 immediately. After release, Req=4'b0100 is served normally with pointer starting at 0.
- Timeout:
  - With CORDIC_TIMEOUT_EN, TIMEOUT=32, Ready never asserted -> Res_Valid with Res_Err=1, AM=PM=0, 32 cycles after WAIT entry.
  - Without the macro -> Busy stays 1 indefinitely.
